stack_alu_sequencer: RTL and testbench

- Reverse-Polish expression sequencer in front of the 32-entry stack ALU.
- Accepts a token stream (operand / ADD / MUL / END) on a valid/ready handshake and drives the ALU's opcode and data pins one command per cycle.
- Expands each operator into the ALU micro-sequence compute → pop → pop → push-result, because the ALU computes without consuming operands.
- Returns the final value, a sticky overflow flag and an error code on a result handshake.

---
 rtl/stack_alu_pkg.sv | 40 ++++
 rtl/stack_alu_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_stack_alu_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU expression sequencer:
// ALU opcode constants, token kinds, result error codes and sequencer states.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    TOK_OPND = 2'b00,
    TOK_ADD  = 2'b01,
    TOK_MUL  = 2'b10,
    TOK_END  = 2'b11
  } tok_type_t;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_FULL      = 3'd2,
    ERR_BAD_END   = 3'd3,
    ERR_SP        = 3'd4
  } err_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_OP,
    ST_EXEC,
    ST_POP1,
    ST_POP2,
    ST_PUSH_RES,
    ST_FIN_POP,
    ST_FIN_CAP,
    ST_FLUSH,
    ST_DISCARD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/stack_alu_sequencer.sv
// Reverse-Polish expression sequencer driving a 32-entry stack ALU.
// Each operator becomes compute -> pop -> pop -> push-result, because the ALU
// computes from its top two entries without consuming them.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (also resets the ALU)
//   tok_valid/tok_ready token handshake; tok_type 00 operand, 01 ADD, 10 MUL, 11 END
//   tok_data            signed operand value
//   alu_opcode/alu_data command and data to the ALU (acted on at the edge ending each state)
//   alu_out/alu_ovf/alu_sp ALU output data, overflow flag and stack pointer
//   res_valid/res_ready result handshake; res_data, res_ovf (sticky), res_err
//   dbg_state           current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1; valid holds its payload until then, and ready never depends on valid.
//
// Optional build macro SEQ_SPCHK_EN: while idle, compare alu_sp against the
// shadow depth and abort with error 4 on mismatch, flushing alu_sp entries.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N         = 32,
  parameter int MAX_DEPTH = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_type,
  input  logic [N-1:0] tok_data,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_data,
  input  logic [N-1:0] alu_out,
  input  logic         alu_ovf,
  input  logic [4:0]   alu_sp,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_ovf,
  output logic [2:0]   res_err,
  output state_t       dbg_state
);

  localparam logic [4:0] MAX_D = 5'(MAX_DEPTH);

  state_t       state_q, state_d;
  logic [4:0]   depth_q, depth_d;
  logic [N-1:0] alu_data_q, alu_data_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic         ovf_q, ovf_d;
  err_t         err_q, err_d;
  logic         is_mul_q, is_mul_d;
  // Remembers whether the token that caused the error was END: if so there is
  // nothing left to discard after flushing.
  logic         end_err_q, end_err_d;
  logic         tok_ready_q, tok_ready_d;

  tok_type_t tok_kind;
  logic      tok_fire;
  logic      sp_mismatch;

  assign tok_kind = tok_type_t'(tok_type);

`ifdef SEQ_SPCHK_EN
  assign sp_mismatch = (state_q == ST_IDLE) && (alu_sp != depth_q);
`else
  logic unused_sp;
  assign unused_sp   = ^alu_sp;
  assign sp_mismatch = 1'b0;
`endif

  // tok_ready is registered from the next state so it is 0 under reset; a
  // stack-pointer mismatch blocks acceptance for the cycle it is detected.
  assign tok_ready = tok_ready_q && !sp_mismatch;
  assign tok_fire  = tok_valid && tok_ready;

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    alu_data_d = alu_data_q;
    res_data_d = res_data_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    is_mul_d   = is_mul_q;
    end_err_d  = end_err_q;
    case (state_q)
      ST_IDLE: begin
`ifdef SEQ_SPCHK_EN
        if (sp_mismatch) begin
          state_d   = ST_FLUSH;
          err_d     = ERR_SP;
          depth_d   = alu_sp;
          end_err_d = 1'b0;
        end else
`endif
        if (tok_fire) begin
          case (tok_kind)
            TOK_OPND: begin
              if (depth_q == MAX_D) begin
                state_d   = ST_FLUSH;
                err_d     = ERR_FULL;
                end_err_d = 1'b0;
              end else begin
                alu_data_d = tok_data;
                state_d    = ST_PUSH_OP;
              end
            end
            TOK_ADD, TOK_MUL: begin
              if (depth_q < 5'd2) begin
                state_d   = ST_FLUSH;
                err_d     = ERR_UNDERFLOW;
                end_err_d = 1'b0;
              end else begin
                is_mul_d = (tok_kind == TOK_MUL);
                state_d  = ST_EXEC;
              end
            end
            default: begin
              if (depth_q != 5'd1) begin
                state_d   = ST_FLUSH;
                err_d     = ERR_BAD_END;
                end_err_d = 1'b1;
              end else begin
                state_d = ST_FIN_POP;
              end
            end
          endcase
        end
      end
      ST_PUSH_OP: begin
        depth_d = depth_q + 5'd1;
        state_d = ST_IDLE;
      end
      ST_EXEC: state_d = ST_POP1;
      ST_POP1: begin
        // The compute result is still on alu_out here; the pop at this edge
        // replaces it, so take it now and push it back from alu_data later.
        alu_data_d = alu_out;
        ovf_d      = ovf_q | alu_ovf;
        state_d    = ST_POP2;
      end
      ST_POP2: state_d = ST_PUSH_RES;
      ST_PUSH_RES: begin
        depth_d = depth_q - 5'd1;
        state_d = ST_IDLE;
      end
      ST_FIN_POP: begin
        depth_d = depth_q - 5'd1;
        state_d = ST_FIN_CAP;
      end
      ST_FIN_CAP: begin
        res_data_d = alu_out;
        state_d    = ST_DONE;
      end
      ST_FLUSH: begin
        if (depth_q > 5'd1) begin
          depth_d = depth_q - 5'd1;
        end else begin
          depth_d = 5'd0;
          state_d = end_err_q ? ST_DONE : ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (tok_fire && (tok_kind == TOK_END)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          ovf_d   = 1'b0;
          err_d   = ERR_OK;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tok_ready_d = (state_d == ST_IDLE) || (state_d == ST_DISCARD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= 5'd0;
      alu_data_q  <= '0;
      res_data_q  <= '0;
      ovf_q       <= 1'b0;
      err_q       <= ERR_OK;
      is_mul_q    <= 1'b0;
      end_err_q   <= 1'b0;
      tok_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      alu_data_q  <= alu_data_d;
      res_data_q  <= res_data_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      is_mul_q    <= is_mul_d;
      end_err_q   <= end_err_d;
      tok_ready_q <= tok_ready_d;
    end
  end

  always_comb begin
    alu_opcode = OP_NOP;
    case (state_q)
      ST_PUSH_OP, ST_PUSH_RES:      alu_opcode = OP_PUSH;
      ST_EXEC:                      alu_opcode = is_mul_q ? OP_MUL : OP_ADD;
      ST_POP1, ST_POP2, ST_FIN_POP: alu_opcode = OP_POP;
      ST_FLUSH:                     alu_opcode = (depth_q != 5'd0) ? OP_POP : OP_NOP;
      default:                      alu_opcode = OP_NOP;
    endcase
  end

  assign alu_data  = alu_data_q;
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = (err_q == ERR_OK) ? res_data_q : '0;
  assign res_ovf   = ovf_q;
  assign res_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural 32-entry stack ALU, token driver,
// result scoreboard fed by an RPN reference model, table vectors plus
// hand-written corner sequences and random expressions.
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int EW = 52; // {data[32], ovf, err[3], pops[8], pushes[8]}

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] d;
  } tok_s;

  typedef struct packed {
    tok_s [7:0]  toks;
    logic [3:0]  n;
    logic [31:0] d;
    logic        o;
    logic [2:0]  e;
  } vec_t;

  logic        clk, rst;
  logic        tok_valid, tok_ready;
  logic [1:0]  tok_type;
  logic [31:0] tok_data;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_data, alu_out;
  logic        alu_ovf;
  logic [4:0]  alu_sp;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_ovf;
  logic [2:0]  res_err;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  tok_s          seq[$];
  logic [2:0]    op_log[$];
  logic [2:0]    exp_ops[$];
  logic          seq_chk_en = 1'b0;
  int            pop_cnt = 0;
  int            push_cnt = 0;
  vec_t          vecs[9];

  stack_alu_sequencer #(.N(32), .MAX_DEPTH(31)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .alu_sp(alu_sp),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .res_err(res_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural stack ALU ----------------
  logic [31:0] m_stk[32];
  always @(posedge clk or posedge rst) begin
    logic signed [31:0] a, b, r;
    longint p;
    if (rst) begin
      alu_sp  <= 5'd0;
      alu_out <= 32'd0;
      alu_ovf <= 1'b0;
    end else begin
      a = m_stk[alu_sp - 5'd2];
      b = m_stk[alu_sp - 5'd1];
      case (alu_opcode)
        OP_ADD: begin
          r = a + b;
          alu_out <= r;
          alu_ovf <= (a[31] == b[31]) && (r[31] != a[31]);
        end
        OP_MUL: begin
          p = longint'(a) * longint'(b);
          r = p[31:0];
          alu_out <= r;
          alu_ovf <= (p != longint'(r));
        end
        OP_PUSH: begin
          m_stk[alu_sp] <= alu_data;
          alu_sp <= alu_sp + 5'd1;
        end
        OP_POP: begin
          alu_out <= m_stk[alu_sp - 5'd1];
          alu_sp <= alu_sp - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tok_s mk(input tok_type_t t, input logic [31:0] d);
    tok_s tk;
    tk.t = t;
    tk.d = d;
    return tk;
  endfunction

  // RPN reference: result value, sticky overflow, error code and the number of
  // pops/pushes the ALU should see for the token list in seq.
  task automatic model_seq(output logic [EW-1:0] item);
    logic signed [31:0] stk[$];
    logic signed [31:0] a, b, r;
    longint p;
    logic [31:0] data = 0;
    logic ovf = 0;
    logic [2:0] err = 0;
    int pops = 0, pushes = 0;
    logic discard = 0, done = 0;
    for (int i = 0; i < seq.size() && !done; i++) begin
      if (discard) begin
        if (seq[i].t == TOK_END) done = 1;
      end else begin
        case (seq[i].t)
          TOK_OPND: begin
            if (stk.size() == 31) begin
              err = 2; pops += stk.size(); stk.delete(); discard = 1;
            end else begin
              stk.push_back(seq[i].d); pushes++;
            end
          end
          TOK_ADD, TOK_MUL: begin
            if (stk.size() < 2) begin
              err = 1; pops += stk.size(); stk.delete(); discard = 1;
            end else begin
              b = stk.pop_back();
              a = stk.pop_back();
              if (seq[i].t == TOK_ADD) begin
                r = a + b;
                ovf |= (a[31] == b[31]) && (r[31] != a[31]);
              end else begin
                p = longint'(a) * longint'(b);
                r = p[31:0];
                ovf |= (p != longint'(r));
              end
              stk.push_back(r); pops += 2; pushes++;
            end
          end
          default: begin
            if (stk.size() != 1) begin
              err = 3; pops += stk.size(); stk.delete();
            end else begin
              data = stk.pop_back(); pops++;
            end
            done = 1;
          end
        endcase
      end
    end
    if (err != 0) data = 0;
    item = {data, ovf, err, 8'(pops), 8'(pushes)};
  endtask

  task automatic send_tok(input tok_s tk);
    int waited = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = tk.t;
    tok_data  = tk.d;
    while (!tok_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!tok_ready) begin
      chk("tok_accept_timeout", 64'(tok_ready), 64'd1);
      tok_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 tok_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("result_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // use_tab: take data/ovf/err from the caller, op counts from the model.
  task automatic run_seq(input logic use_tab, input logic [31:0] td, input logic to,
                         input logic [2:0] te, input logic drain);
    logic [EW-1:0] item;
    model_seq(item);
    if (use_tab) item = {td, to, te, item[15:0]};
    exp_q.push_back(item);
    foreach (seq[i]) send_tok(seq[i]);
    if (drain) wait_drain();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      pop_cnt = 0;
      push_cnt = 0;
      op_log.delete();
    end else begin
      if (alu_opcode == OP_POP) pop_cnt++;
      if (alu_opcode == OP_PUSH) push_cnt++;
      if (alu_opcode != OP_NOP) op_log.push_back(alu_opcode);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(res_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", 64'(res_data), 64'(e[51:20]));
          chk("res_ovf", 64'(res_ovf), 64'(e[19]));
          chk("res_err", 64'(res_err), 64'(e[18:16]));
          chk("pop_count", 64'(pop_cnt), 64'(e[15:8]));
          chk("push_count", 64'(push_cnt), 64'(e[7:0]));
          chk("alu_sp_at_done", 64'(alu_sp), 64'd0);
        end
        if (seq_chk_en) begin
          chk("op_seq_len", 64'(op_log.size()), 64'(exp_ops.size()));
          for (int i = 0; i < op_log.size() && i < exp_ops.size(); i++)
            chk("op_seq", 64'(op_log[i]), 64'(exp_ops[i]));
          seq_chk_en = 1'b0;
        end
        pop_cnt = 0;
        push_cnt = 0;
        op_log.delete();
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    int n;
    int depth, nopnd, k;
    logic [31:0] v;

    rst = 1'b1; tok_valid = 1'b0; tok_type = 2'b00; tok_data = 32'd0; res_ready = 1'b1;

    for (int i = 0; i < 9; i++) vecs[i] = '0;
    vecs[0].toks[0] = mk(TOK_OPND, 3); vecs[0].toks[1] = mk(TOK_OPND, 4);
    vecs[0].toks[2] = mk(TOK_ADD, 0);  vecs[0].toks[3] = mk(TOK_END, 0);
    vecs[0].n = 4; vecs[0].d = 32'd7;
    vecs[1].toks[0] = mk(TOK_OPND, 5); vecs[1].toks[1] = mk(TOK_OPND, 32'hFFFF_FFFA);
    vecs[1].toks[2] = mk(TOK_MUL, 0);  vecs[1].toks[3] = mk(TOK_OPND, 2);
    vecs[1].toks[4] = mk(TOK_ADD, 0);  vecs[1].toks[5] = mk(TOK_END, 0);
    vecs[1].n = 6; vecs[1].d = 32'hFFFF_FFE4;
    vecs[2].toks[0] = mk(TOK_OPND, 32'h7FFF_FFFF); vecs[2].toks[1] = mk(TOK_OPND, 1);
    vecs[2].toks[2] = mk(TOK_ADD, 0);  vecs[2].toks[3] = mk(TOK_END, 0);
    vecs[2].n = 4; vecs[2].d = 32'h8000_0000; vecs[2].o = 1'b1;
    vecs[3].toks[0] = mk(TOK_OPND, 1); vecs[3].toks[1] = mk(TOK_ADD, 0);
    vecs[3].toks[2] = mk(TOK_OPND, 9); vecs[3].toks[3] = mk(TOK_END, 0);
    vecs[3].n = 4; vecs[3].e = 3'd1;
    vecs[4].toks[0] = mk(TOK_OPND, 1); vecs[4].toks[1] = mk(TOK_OPND, 2);
    vecs[4].toks[2] = mk(TOK_END, 0);
    vecs[4].n = 3; vecs[4].e = 3'd3;
    vecs[5].toks[0] = mk(TOK_END, 0);
    vecs[5].n = 1; vecs[5].e = 3'd3;
    vecs[6].toks[0] = mk(TOK_ADD, 0);  vecs[6].toks[1] = mk(TOK_END, 0);
    vecs[6].n = 2; vecs[6].e = 3'd1;
    vecs[7].toks[0] = mk(TOK_OPND, 32'h0001_0000); vecs[7].toks[1] = mk(TOK_OPND, 32'h0001_0000);
    vecs[7].toks[2] = mk(TOK_MUL, 0);  vecs[7].toks[3] = mk(TOK_END, 0);
    vecs[7].n = 4; vecs[7].d = 32'd0; vecs[7].o = 1'b1;
    vecs[8].toks[0] = mk(TOK_OPND, 2); vecs[8].toks[1] = mk(TOK_OPND, 3);
    vecs[8].toks[2] = mk(TOK_MUL, 0);  vecs[8].toks[3] = mk(TOK_END, 0);
    vecs[8].n = 4; vecs[8].d = 32'd6;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_opcode", 64'(alu_opcode), 64'(OP_NOP));
    chk("rst_alu_data", 64'(alu_data), 64'd0);
    chk("rst_tok_ready", 64'(tok_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_ovf", 64'(res_ovf), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;

    // table vectors
    for (int vi = 0; vi < 9; vi++) begin
      seq.delete();
      for (int t = 0; t < int'(vecs[vi].n); t++) seq.push_back(vecs[vi].toks[t]);
      if (vi == 0) begin
        exp_ops = {OP_PUSH, OP_PUSH, OP_ADD, OP_POP, OP_POP, OP_PUSH, OP_POP};
        seq_chk_en = 1'b1;
      end
      run_seq(1'b1, vecs[vi].d, vecs[vi].o, vecs[vi].e, 1'b1);
    end

    // stack full: 31 operands fit, the 32nd aborts; result held with res_ready low
    seq.delete();
    for (int i = 0; i < 32; i++) seq.push_back(mk(TOK_OPND, 32'(i + 1)));
    seq.push_back(mk(TOK_END, 0));
    res_ready = 1'b0;
    run_seq(1'b1, 32'd0, 1'b0, 3'd2, 1'b0);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("full_done_reached", 64'(res_valid), 64'd1);
    tok_valid = 1'b1; tok_type = TOK_END; tok_data = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", 64'(res_data), 64'd0);
      chk("hold_res_err", 64'(res_err), 64'd2);
      chk("hold_tok_ready", 64'(tok_ready), 64'd0);
    end
    tok_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();

    // reset during POP2 of an ADD
    seq.delete();
    seq.push_back(mk(TOK_OPND, 4)); seq.push_back(mk(TOK_OPND, 5)); seq.push_back(mk(TOK_ADD, 0));
    foreach (seq[i]) send_tok(seq[i]);
    n = 0;
    while (dbg_state != ST_POP2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_pop2", 64'(dbg_state), 64'(ST_POP2));
    rst = 1'b1;
    #1;
    chk("abort_opcode", 64'(alu_opcode), 64'(OP_NOP));
    chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_alu_sp", 64'(alu_sp), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq.delete();
    seq.push_back(mk(TOK_OPND, 2)); seq.push_back(mk(TOK_OPND, 3));
    seq.push_back(mk(TOK_ADD, 0));  seq.push_back(mk(TOK_END, 0));
    run_seq(1'b1, 32'd5, 1'b0, 3'd0, 1'b1);

    // random expressions checked against the reference model
    for (int r = 0; r < 25; r++) begin
      seq.delete();
      depth = 0;
      k = 0;
      nopnd = $urandom_range(1, 6);
      if ($urandom_range(0, 5) == 0) seq.push_back(mk(TOK_ADD, 0));
      while (k < nopnd || depth > 1) begin
        if (k < nopnd && (depth < 2 || $urandom_range(0, 1) == 1)) begin
          if ($urandom_range(0, 3) == 0) v = $urandom();
          else v = 32'($urandom_range(0, 20)) - 32'd10;
          seq.push_back(mk(TOK_OPND, v));
          depth++;
          k++;
        end else begin
          seq.push_back(mk(($urandom_range(0, 1) == 1) ? TOK_MUL : TOK_ADD, 0));
          depth--;
        end
      end
      if ($urandom_range(0, 5) == 0) seq.push_back(mk(TOK_OPND, 7));
      seq.push_back(mk(TOK_END, 0));
      run_seq(1'b0, 32'd0, 1'b0, 3'd0, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
